// File: rtl/coco_mem_pkg.sv
// Shared types and widths for the Dragon/CoCo external memory path.
// Grant and FSM encodings are common to the arbiter and its download buffer.
package coco_mem_pkg;

  localparam int MEM_AW = 20;
  localparam int MEM_DW = 8;

  typedef enum logic [1:0] {GNT_NONE, GNT_DL, GNT_RAM, GNT_ROM} gnt_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

endpackage

// File: rtl/dl_latch.sv
// Single-entry buffer for data_io download bytes, relocated by ROM_BASE.
// Tracks overflow when a strobe lands on a full buffer that is not being released.
module dl_latch
  import coco_mem_pkg::*;
#(
  parameter logic [MEM_AW-1:0] ROM_BASE = 20'h80000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [MEM_AW-1:0] ioctl_addr,
  input  logic [MEM_DW-1:0] ioctl_dout,
  input  logic              dl_release,
  output logic              dl_pend,
  output logic [MEM_AW-1:0] dl_addr,
  output logic [MEM_DW-1:0] dl_data,
  output logic              dl_ovf
);

  logic download_q;
  logic dl_accept;
  logic dl_drop;
  logic dl_rise;

  // A strobe coinciding with the release refills the slot instead of dropping.
  assign dl_accept = ioctl_wr && (!dl_pend || dl_release);
  assign dl_drop   = ioctl_wr && dl_pend && !dl_release;
  assign dl_rise   = ioctl_download && !download_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      download_q <= 1'b0;
      dl_pend    <= 1'b0;
      dl_addr    <= '0;
      dl_data    <= '0;
      dl_ovf     <= 1'b0;
    end else begin
      download_q <= ioctl_download;
      if (dl_accept) begin
        dl_pend <= 1'b1;
        dl_addr <= ROM_BASE + ioctl_addr;
        dl_data <= ioctl_dout;
      end else if (dl_release) begin
        dl_pend <= 1'b0;
      end
      dl_ovf <= (dl_ovf && !dl_rise) || dl_drop;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between download writes, CPU RAM and ROM fetch.
// Download wins outright; RAM and ROM alternate on contention.
module sdram_port_arbiter
  import coco_mem_pkg::*;
#(
  parameter int                ACC_CYCLES = 4,
  parameter logic [MEM_AW-1:0] ROM_BASE   = 20'h80000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [MEM_AW-1:0] ioctl_addr,
  input  logic [MEM_DW-1:0] ioctl_dout,
  output logic              dl_ovf,
  input  logic              ram_req,
  input  logic              ram_we,
  input  logic [MEM_AW-1:0] ram_addr,
  input  logic [MEM_DW-1:0] ram_wdata,
  output logic              ram_ack,
  output logic [MEM_DW-1:0] ram_rdata,
  input  logic              rom_req,
  input  logic [MEM_AW-1:0] rom_addr,
  output logic              rom_ack,
  output logic [MEM_DW-1:0] rom_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_din,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic [MEM_DW-1:0] mem_dout,
  output logic              busy,
  output state_t            dbg_state
);

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  // Handshake: ram_req/rom_req are levels held until the matching one-cycle
  // ack; the access is committed once granted, so dropping req early never aborts it.

  state_t            state;
  state_t            state_d;
  gnt_t              gnt;
  gnt_t              pick;
  gnt_t              last_rr;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] sel_addr;
  logic [MEM_DW-1:0] sel_din;
  logic              sel_we;
  logic              dl_pend;
  logic              dl_release;
  logic [MEM_AW-1:0] dl_addr;
  logic [MEM_DW-1:0] dl_data;

  assign dl_release = (state == ST_DONE) && (gnt == GNT_DL);
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;

  dl_latch #(
    .ROM_BASE(ROM_BASE)
  ) u_dl_latch (
    .clk           (clk),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .dl_release    (dl_release),
    .dl_pend       (dl_pend),
    .dl_addr       (dl_addr),
    .dl_data       (dl_data),
    .dl_ovf        (dl_ovf)
  );

  always_comb begin
    state_d = state;
    pick    = GNT_NONE;
    case (state)
      ST_IDLE: begin
        if (dl_pend) begin
          pick = GNT_DL;
        end else if (ram_req && rom_req) begin
          pick = (last_rr == GNT_ROM) ? GNT_RAM : GNT_ROM;
        end else if (ram_req) begin
          pick = GNT_RAM;
        end else if (rom_req) begin
          pick = GNT_ROM;
        end
        if (pick != GNT_NONE) state_d = ST_ACCESS;
      end
      ST_ACCESS: if (cnt == 4'd0) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_we   = 1'b0;
    case (pick)
      GNT_DL: begin
        sel_addr = dl_addr;
        sel_din  = dl_data;
        sel_we   = 1'b1;
      end
      GNT_RAM: begin
        sel_addr = ram_addr;
        sel_din  = ram_wdata;
        sel_we   = ram_we;
      end
      GNT_ROM: sel_addr = rom_addr;
      default: sel_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  // mem_* are loaded on the grant edge so the enables appear for exactly ACC_CYCLES clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= GNT_NONE;
      last_rr   <= GNT_ROM;
      cnt       <= 4'd0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_oe    <= 1'b0;
      mem_we    <= 1'b0;
      ram_ack   <= 1'b0;
      rom_ack   <= 1'b0;
      ram_rdata <= '0;
      rom_rdata <= '0;
    end else begin
      ram_ack <= 1'b0;
      rom_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick != GNT_NONE) begin
            gnt      <= pick;
            cnt      <= CNT_LOAD;
            mem_addr <= sel_addr;
            mem_din  <= sel_din;
            mem_we   <= sel_we;
            mem_oe   <= !sel_we;
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            mem_oe <= 1'b0;
            mem_we <= 1'b0;
            if (gnt == GNT_RAM) begin
              ram_ack <= 1'b1;
              if (!mem_we) ram_rdata <= mem_dout;
            end
            if (gnt == GNT_ROM) begin
              rom_ack   <= 1'b1;
              rom_rdata <= mem_dout;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (gnt == GNT_RAM || gnt == GNT_ROM) last_rr <= gnt;
        end
        default: gnt <= GNT_NONE;
      endcase
    end
  end

endmodule
